cmp_sort_ctrl: RTL and testbench

- Sequential sorter for a small vector of unsigned values; one shared magnitude comparator is reused for every compare-and-swap step.
- Bubble-sort schedule with early exit.
- Accepts a start pulse, sorts DEPTH elements in place, then presents the sorted vector with a one-cycle done pulse.
- Sits between a host/control FSM and any consumer needing ordered data (max/min selection, median, priority ordering).

---
 rtl/cmp_sort_pkg.sv | 17 +
 rtl/cmp_unit.sv | 16 +
 rtl/cmp_sort_ctrl.sv | 125 ++++++++++++
 tb/tb_cmp_sort_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cmp_sort_pkg.sv
// Shared definitions for the sequential compare-and-swap sorter.
package cmp_sort_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;

  function automatic bit depth_ok(input int d);
    return (d >= DEPTH_MIN) && (d <= DEPTH_MAX);
  endfunction

endpackage

// File: rtl/cmp_unit.sv
// Combinational unsigned magnitude comparator, shared by all sort steps.
module cmp_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             agb,
  output logic             asb,
  output logic             aeb
);

  assign agb = (a > b);
  assign asb = (a < b);
  assign aeb = (a == b);

endmodule

// File: rtl/cmp_sort_ctrl.sv
// In-place bubble sorter with early exit; one comparator serves every
// compare-and-swap step, the element pair being selected by the index counter.
module cmp_sort_ctrl
  import cmp_sort_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   ascending,
  input  logic [DEPTH*WIDTH-1:0] din,
  output logic                   busy,
  output logic                   done,
  output logic [DEPTH*WIDTH-1:0] dout,
  output logic [7:0]             swap_cnt
);

  localparam int IW = $clog2(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_depth_chk
    $error("cmp_sort_ctrl: DEPTH must lie in 2..16");
  end

  state_t            r_state;
  logic [WIDTH-1:0]  r_el [DEPTH];
  logic [IW-1:0]     r_i;
  logic [IW-1:0]     r_pass;
  logic              r_asc;
  logic              r_psw;
  logic              r_busy;
  logic              r_done;
  logic [7:0]        r_swaps;

  logic [IW-1:0]     w_ip1;
  logic [IW-1:0]     w_last;
  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;
  logic              w_agb;
  logic              w_asb;
  logic              w_aeb;
  logic              w_swap;
  logic              w_pass_end;

  assign w_ip1      = r_i + 1'b1;
  assign w_last     = IW'(DEPTH - 2) - r_pass;
  assign w_pass_end = (r_i == w_last);
  assign w_a        = r_el[r_i];
  assign w_b        = r_el[w_ip1];

  cmp_unit #(.WIDTH(WIDTH)) u_cmp (
    .a   (w_a),
    .b   (w_b),
    .agb (w_agb),
    .asb (w_asb),
    .aeb (w_aeb)
  );

  // Equal elements never swap, which keeps the sort stable.
  assign w_swap = ~w_aeb & (r_asc ? w_agb : w_asb);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_i     <= '0;
      r_pass  <= '0;
      r_psw   <= 1'b0;
      r_asc   <= 1'b0;
      r_swaps <= '0;
      for (int k = 0; k < DEPTH; k++) r_el[k] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            for (int k = 0; k < DEPTH; k++) r_el[k] <= din[k*WIDTH +: WIDTH];
            r_asc   <= ascending;
            r_swaps <= '0;
            r_i     <= '0;
            r_pass  <= '0;
            r_psw   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_SORT;
          end
        end
        ST_SORT: begin
          if (w_swap) begin
            r_el[r_i]   <= w_b;
            r_el[w_ip1] <= w_a;
            r_swaps     <= r_swaps + 8'd1;
          end
          if (w_pass_end) begin
            // A clean pass (counting this cycle) or the final pass ends the sort.
            if (!(r_psw || w_swap) || (r_pass == IW'(DEPTH - 2))) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_pass <= r_pass + 1'b1;
              r_i    <= '0;
              r_psw  <= 1'b0;
            end
          end else begin
            r_i   <= w_ip1;
            r_psw <= r_psw | w_swap;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_dout
    assign dout[k*WIDTH +: WIDTH] = r_el[k];
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign swap_cnt = r_swaps;

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Scoreboard bench for cmp_sort_ctrl at DEPTH=4 and DEPTH=8.
module tb_cmp_sort_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        asc;
  logic        start4, start8;
  logic [15:0] din4;
  logic [31:0] din8;
  logic        busy4, done4, busy8, done8;
  logic [15:0] dout4;
  logic [31:0] dout8;
  logic [7:0]  sc4, sc8;

  always #5 clk = ~clk;

  cmp_sort_ctrl #(.WIDTH(4), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .ascending(asc), .din(din4),
    .busy(busy4), .done(done4), .dout(dout4), .swap_cnt(sc4)
  );

  cmp_sort_ctrl #(.WIDTH(4), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .ascending(asc), .din(din8),
    .busy(busy8), .done(done8), .dout(dout8), .swap_cnt(sc8)
  );

  int          sel;
  logic        busy_m, done_m;
  logic [31:0] dout_m;
  logic [7:0]  sc_m;

  always_comb begin
    busy_m = (sel == 0) ? busy4 : busy8;
    done_m = (sel == 0) ? done4 : done8;
    dout_m = (sel == 0) ? {16'h0, dout4} : dout8;
    sc_m   = (sel == 0) ? sc4 : sc8;
  end

  typedef struct {
    logic [31:0] vec;
    int          swaps;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat, nbusy;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic void ref_sort(input int n, input logic [31:0] v, input logic a,
                                   output logic [31:0] res, output int inv);
    int e[8];
    int t, j;
    for (int k = 0; k < n; k++) e[k] = int'(v[k*4 +: 4]);
    inv = 0;
    for (int p = 0; p < n; p++)
      for (int q = p + 1; q < n; q++)
        if (a ? (e[p] > e[q]) : (e[p] < e[q])) inv++;
    for (int k = 1; k < n; k++) begin
      t = e[k];
      j = k - 1;
      while (j >= 0 && (a ? (e[j] > t) : (e[j] < t))) begin
        e[j+1] = e[j];
        j--;
      end
      e[j+1] = t;
    end
    res = '0;
    for (int k = 0; k < n; k++) res[k*4 +: 4] = 4'(e[k]);
  endfunction

  task automatic launch(input int s, input logic [31:0] v, input logic a,
                        input logic [31:0] exp_v, input int exp_sw, input bit push);
    sel = s;
    @(negedge clk);
    if (s == 0) begin din4 = v[15:0]; start4 = 1'b1; end
    else        begin din8 = v;       start8 = 1'b1; end
    asc = a;
    if (push) sb_q.push_back('{exp_v, exp_sw});
    @(posedge clk); #1;
    start4 = 1'b0;
    start8 = 1'b0;
    lat   = 1;
    nbusy = 0;
  endtask

  task automatic wait_done(input int exp_lat, input int exp_busy);
    exp_t e;
    int   n;
    n = (sel == 0) ? 4 : 8;
    while (!done_m && lat < 200) begin
      if (busy_m) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    check_val("done_seen", done_m, 1);
    check_val("busy_with_done", busy_m, 0);
    e = sb_q.pop_front();
    check_val("dout", dout_m, e.vec);
    check_val("swap_cnt", sc_m, e.swaps);
    if (exp_lat > 0) check_val("latency", lat, exp_lat);
    else check_val("latency_in_range", (lat >= n && lat <= n*(n-1)/2 + 1), 1);
    if (exp_busy >= 0) check_val("busy_cycles", nbusy, exp_busy);
    @(posedge clk); #1;
    check_val("done_one_cycle", done_m, 0);
    check_val("dout_hold", dout_m, e.vec);
  endtask

  initial begin
    logic [31:0] v, res;
    int          inv;
    logic        a;

    rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
    din4 = '0; din8 = '0; asc = 1'b1; sel = 0;

    repeat (2) begin
      @(posedge clk); #1;
      check_val("rst_busy4", busy4, 0);
      check_val("rst_done4", done4, 0);
      check_val("rst_dout4", dout4, 0);
      check_val("rst_swap4", sc4, 0);
      check_val("rst_dout8", dout8, 0);
      check_val("rst_busy8", busy8, 0);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_val("idle_busy", busy4, 0);
    check_val("idle_done", done4, 0);

    // reverse input, ascending: 6 compares, all swapping
    launch(0, 32'h1379, 1'b1, 32'h9731, 6, 1'b1);
    wait_done(7, 6);
    // already ordered: single clean pass
    launch(0, 32'h8642, 1'b1, 32'h8642, 0, 1'b1);
    wait_done(4, 3);
    // descending with ties and extremes
    launch(0, 32'h05F5, 1'b0, 32'h055F, 1, 1'b1);
    wait_done(6, 5);

    // start pulsed during SORT with a different vector must be ignored
    launch(0, 32'h1379, 1'b1, 32'h9731, 6, 1'b1);
    if (busy_m) nbusy++;
    @(negedge clk);
    din4 = 16'h0000; asc = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat++;
    wait_done(7, 6);
    @(posedge clk); #1;
    check_val("start_not_queued", busy4, 0);

    // reset sampled at the end of the 2nd SORT cycle
    launch(0, 32'h1379, 1'b1, 32'h0, 0, 1'b0);
    @(posedge clk); #1;
    check_val("midsort_busy", busy4, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("abort_busy", busy4, 0);
    check_val("abort_done", done4, 0);
    check_val("abort_dout", dout4, 0);
    check_val("abort_swap", sc4, 0);
    repeat (8) begin
      @(posedge clk); #1;
      check_val("abort_no_done", done4, 0);
    end
    launch(0, 32'h05F5, 1'b0, 32'h055F, 1, 1'b1);
    wait_done(6, 5);

    for (int s = 0; s < 2; s++) begin
      for (int it = 0; it < 1000; it++) begin
        v = $urandom;
        if (s == 0) v[31:16] = '0;
        a = 1'($urandom_range(0, 1));
        ref_sort((s == 0) ? 4 : 8, v, a, res, inv);
        launch(s, v, a, res, inv, 1'b1);
        wait_done(-1, -1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
